// File: rtl/cia_pkg.sv
// Shared types for the CIA interrupt controller: ICR source bits and the
// selectable chip variant that sets IRQ latency.
package cia;

  typedef logic [7:0] reg8_t;

  // Bit order matches the ICR layout: {flag, sp, alarm, tb, ta} = bits 4:0.
  typedef struct packed {
    logic flag;
    logic sp;
    logic alarm;
    logic tb;
    logic ta;
  } icr_t;

  typedef enum logic {
    MOS6526 = 1'b0,
    MOS8521 = 1'b1
  } model_t;

endpackage

// File: rtl/cia_interrupt.sv
// CIA interrupt control register: sticky source flags, mask, and the delayed
// IRQ flag whose latency depends on the chip variant.
module cia_interrupt
  import cia::*;
#(
  parameter cia::model_t MODEL = cia::MOS6526
) (
  input  logic        clk,
  input  logic        res,
  input  logic        phi2_dn,
  input  logic        icr_r,
  input  logic        icr_w,
  input  cia::reg8_t  data,
  input  logic        ta_int,
  input  logic        tb_int,
  input  logic        alarm,
  input  logic        sp_int,
  input  logic        flag_n,
  output cia::reg8_t  regs,
  output logic        irq_n
);

  icr_t       icr;
  icr_t       events;
  logic [4:0] icr_new;
  logic [4:0] mask;
  logic [4:0] mask_new;
  logic       flag_q;
  logic       ir;
  logic       stage1;
  logic       stage2;
  logic       pending;
  logic       delayed_set;
  logic       unused_data;

  assign unused_data = ^data[6:5];

  always_comb begin
    events       = '0;
    events.flag  = flag_q & ~flag_n;
    events.sp    = sp_int;
    events.alarm = alarm;
    events.tb    = tb_int;
    events.ta    = ta_int;

    // A read clears the flags, but an event in the same cycle still lands.
    icr_new = (icr_r ? 5'b00000 : icr) | events;

    mask_new = mask;
    if (icr_w) begin
      if (data[7]) mask_new = mask | data[4:0];
      else         mask_new = mask & ~data[4:0];
    end

    pending     = |(icr_new & mask_new);
    delayed_set = (MODEL == MOS8521) ? stage1 : stage2;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      icr    <= '0;
      mask   <= '0;
      flag_q <= 1'b1;
      stage1 <= 1'b0;
      stage2 <= 1'b0;
      ir     <= 1'b0;
    end else if (phi2_dn) begin
      flag_q <= flag_n;
      icr    <= icr_new;
      mask   <= mask_new;
      // stage1 is recomputed from post-read state, so a read only keeps it
      // armed when a fresh event arrived in the same cycle.
      stage1 <= pending;
      stage2 <= icr_r ? 1'b0 : stage1;
      ir     <= icr_r ? 1'b0 : (ir | delayed_set);
    end
  end

  assign regs  = {ir, 2'b00, icr};
  assign irq_n = ~ir;

endmodule
